// File: rtl/vend_ctrl.sv
// Vending machine controller: coin credit accumulation, vend handshake and nickel change payout.
// Optional coin-return support is compiled in when the REFUND_EN macro is defined.
module vend_ctrl #(
  parameter int PRICE      = 35,
  parameter int MAX_CREDIT = 100
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       q_in,
  input  logic       d_in,
  input  logic       n_in,
  input  logic       sel,
  input  logic       vend_done,
  input  logic       coin_ack,
`ifdef REFUND_EN
  input  logic       refund,
`endif
  output logic       vend_req,
  output logic       coin_req,
  output logic [7:0] credit,
  output logic       busy,
  output logic       coin_reject,
  output logic       deny
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_VEND   = 2'd2,
    S_CHANGE = 2'd3
  } state_t;

  localparam logic [7:0] PRICE_C  = 8'(PRICE);
  localparam logic [8:0] MAX_C    = 9'(MAX_CREDIT);
  localparam logic [7:0] NICKEL_C = 8'd5;

  state_t     state_q, state_d;
  logic [7:0] credit_q, credit_d;
  logic       vend_req_q, coin_req_q, busy_q, coin_reject_q, deny_q;
  logic       reject_d, deny_d;
  logic       refund_s, coin_any_s;
  logic [7:0] coin_val_s;
  logic [8:0] sum_s;

  // Next-state and credit arithmetic; coin priority is quarter > dime > nickel.
  always_comb begin
`ifdef REFUND_EN
    refund_s = refund;
`else
    refund_s = 1'b0;
`endif
    coin_any_s = q_in | d_in | n_in;
    if (q_in) begin
      coin_val_s = 8'd25;
    end else if (d_in) begin
      coin_val_s = 8'd10;
    end else if (n_in) begin
      coin_val_s = 8'd5;
    end else begin
      coin_val_s = 8'd0;
    end
    sum_s    = {1'b0, credit_q} + {1'b0, coin_val_s};
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;
    deny_d   = 1'b0;

    case (state_q)
      S_IDLE, S_CREDIT: begin
        if (coin_any_s) begin
          if (sum_s > MAX_C) begin
            reject_d = 1'b1;
          end else begin
            credit_d = sum_s[7:0];
          end
        end else begin
          credit_d = credit_q;
        end
        // sel is judged on the registered credit, never on a same-cycle coin
        if (refund_s && (state_q == S_CREDIT)) begin
          state_d = S_CHANGE;
        end else if (sel && (credit_q >= PRICE_C)) begin
          state_d = S_VEND;
        end else begin
          deny_d  = sel;
          state_d = (credit_d == 8'd0) ? S_IDLE : S_CREDIT;
        end
      end
      S_VEND: begin
        reject_d = coin_any_s;
        if (vend_done) begin
          credit_d = credit_q - PRICE_C;
          state_d  = (credit_d == 8'd0) ? S_IDLE : S_CHANGE;
        end else begin
          state_d = S_VEND;
        end
      end
      S_CHANGE: begin
        reject_d = coin_any_s;
        if (coin_ack) begin
          credit_d = credit_q - NICKEL_C;
          state_d  = (credit_d == 8'd0) ? S_IDLE : S_CHANGE;
        end else begin
          state_d = S_CHANGE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = 8'd0;
      end
    endcase
  end

  // State, credit and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      credit_q      <= 8'd0;
      vend_req_q    <= 1'b0;
      coin_req_q    <= 1'b0;
      busy_q        <= 1'b0;
      coin_reject_q <= 1'b0;
      deny_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      vend_req_q    <= (state_d == S_VEND);
      coin_req_q    <= (state_d == S_CHANGE);
      busy_q        <= (state_d == S_VEND) || (state_d == S_CHANGE);
      coin_reject_q <= reject_d;
      deny_q        <= deny_d;
    end
  end

  assign vend_req    = vend_req_q;
  assign coin_req    = coin_req_q;
  assign credit      = credit_q;
  assign busy        = busy_q;
  assign coin_reject = coin_reject_q;
  assign deny        = deny_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed scoreboard bench for vend_ctrl (PRICE=35, MAX_CREDIT=100).
module tb_vend_ctrl;

  localparam logic [7:0] Q   = 8'h01;
  localparam logic [7:0] D   = 8'h02;
  localparam logic [7:0] N   = 8'h04;
  localparam logic [7:0] SEL = 8'h08;
  localparam logic [7:0] VD  = 8'h10;
  localparam logic [7:0] CA  = 8'h20;
  localparam logic [7:0] RF  = 8'h40;
  localparam logic [7:0] RST = 8'h80;
  localparam logic [7:0] NOP = 8'h00;

  typedef struct packed {
    logic [7:0] credit;
    logic       vreq;
    logic       creq;
    logic       busy;
    logic       rej;
    logic       deny;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn, q_in, d_in, n_in, sel, vend_done, coin_ack;
`ifdef REFUND_EN
  logic       refund;
`endif
  logic       vend_req, coin_req, busy, coin_reject, deny;
  logic [7:0] credit;

  int   compared   = 0;
  int   mismatched = 0;
  exp_t sb[$];

  vend_ctrl #(.PRICE(35), .MAX_CREDIT(100)) dut (
    .clk(clk), .rstn(rstn), .q_in(q_in), .d_in(d_in), .n_in(n_in), .sel(sel),
    .vend_done(vend_done), .coin_ack(coin_ack),
`ifdef REFUND_EN
    .refund(refund),
`endif
    .vend_req(vend_req), .coin_req(coin_req), .credit(credit), .busy(busy),
    .coin_reject(coin_reject), .deny(deny)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [7:0] stim, input logic [7:0] c,
                      input logic vr, input logic cr, input logic bz, input logic rj, input logic dn);
    exp_t e;
    @(negedge clk);
    rstn      = ~stim[7];
    q_in      = stim[0];
    d_in      = stim[1];
    n_in      = stim[2];
    sel       = stim[3];
    vend_done = stim[4];
    coin_ack  = stim[5];
`ifdef REFUND_EN
    refund    = stim[6];
`endif
    sb.push_back('{credit: c, vreq: vr, creq: cr, busy: bz, rej: rj, deny: dn});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(tag, "credit",      credit,             e.credit);
    chk(tag, "vend_req",    {7'd0, vend_req},   {7'd0, e.vreq});
    chk(tag, "coin_req",    {7'd0, coin_req},   {7'd0, e.creq});
    chk(tag, "busy",        {7'd0, busy},       {7'd0, e.busy});
    chk(tag, "coin_reject", {7'd0, coin_reject}, {7'd0, e.rej});
    chk(tag, "deny",        {7'd0, deny},       {7'd0, e.deny});
  endtask

  initial begin
    rstn = 1'b0; q_in = 1'b0; d_in = 1'b0; n_in = 1'b0;
    sel = 1'b0; vend_done = 1'b0; coin_ack = 1'b0;
`ifdef REFUND_EN
    refund = 1'b0;
`endif
    // reset, with inputs active during reset having no effect
    step("rst_busy_in", RST | Q | SEL, 8'd0,  0, 0, 0, 0, 0);
    step("rst",         RST,           8'd0,  0, 0, 0, 0, 0);
    // exact-price vend, no change
    step("s1_q",        Q,             8'd25, 0, 0, 0, 0, 0);
    step("s1_d",        D,             8'd35, 0, 0, 0, 0, 0);
    step("s1_sel",      SEL,           8'd35, 1, 0, 1, 0, 0);
    step("s1_hold",     NOP,           8'd35, 1, 0, 1, 0, 0);
    step("s1_vd",       VD,            8'd0,  0, 0, 0, 0, 0);
    step("idle_ca",     CA,            8'd0,  0, 0, 0, 0, 0);
    step("idle_vd",     VD,            8'd0,  0, 0, 0, 0, 0);
    // overpay, three nickels of change; mixed acks only act in matching state
    step("s2_q1",       Q,             8'd25, 0, 0, 0, 0, 0);
    step("s2_q2",       Q,             8'd50, 0, 0, 0, 0, 0);
    step("s2_sel",      SEL,           8'd50, 1, 0, 1, 0, 0);
    step("s2_vd_ca",    VD | CA,       8'd15, 0, 1, 1, 0, 0);
    step("s2_ca1_vd",   CA | VD,       8'd10, 0, 1, 1, 0, 0);
    step("s2_ca2",      CA,            8'd5,  0, 1, 1, 0, 0);
    step("s2_ca3",      CA,            8'd0,  0, 0, 0, 0, 0);
    // insufficient credit
    step("s3_d",        D,             8'd10, 0, 0, 0, 0, 0);
    step("s3_sel",      SEL,           8'd10, 0, 0, 0, 0, 1);
    step("s3_after",    NOP,           8'd10, 0, 0, 0, 0, 0);
    // ceiling
    step("s4_q1",       Q,             8'd35, 0, 0, 0, 0, 0);
    step("s4_q2",       Q,             8'd60, 0, 0, 0, 0, 0);
    step("s4_q3",       Q,             8'd85, 0, 0, 0, 0, 0);
    step("s4_d",        D,             8'd95, 0, 0, 0, 0, 0);
    step("s4_q_rej",    Q,             8'd95, 0, 0, 0, 1, 0);
    step("s4_n",        N,             8'd100, 0, 0, 0, 0, 0);
    step("s4_qd_rej",   Q | D,         8'd100, 0, 0, 0, 1, 0);
    step("s4_quiet",    NOP,           8'd100, 0, 0, 0, 0, 0);
    step("s4_rst",      RST,           8'd0,  0, 0, 0, 0, 0);
    // sel with same-cycle coin: compared on old credit, coin still added
    step("s5_q",        Q,             8'd25, 0, 0, 0, 0, 0);
    step("s5_d",        D,             8'd35, 0, 0, 0, 0, 0);
    step("s5_sel_n",    SEL | N,       8'd40, 1, 0, 1, 0, 0);
    step("s5_vd",       VD,            8'd5,  0, 1, 1, 0, 0);
    step("s5_ca",       CA,            8'd0,  0, 0, 0, 0, 0);
    // coins refused while busy, sel ignored, reset abandons change
    step("s6_q1",       Q,             8'd25, 0, 0, 0, 0, 0);
    step("s6_q2",       Q,             8'd50, 0, 0, 0, 0, 0);
    step("s6_sel",      SEL,           8'd50, 1, 0, 1, 0, 0);
    step("s6_n_vend",   N,             8'd50, 1, 0, 1, 1, 0);
    step("s6_sel_vend", SEL,           8'd50, 1, 0, 1, 0, 0);
    step("s6_vd",       VD,            8'd15, 0, 1, 1, 0, 0);
    step("s6_d_chg",    D,             8'd15, 0, 1, 1, 1, 0);
    step("s6_ca",       CA,            8'd10, 0, 1, 1, 0, 0);
    step("s6_rst",      RST | CA,      8'd0,  0, 0, 0, 0, 0);
    step("s6_n",        N,             8'd5,  0, 0, 0, 0, 0);
    step("s6_rst2",     RST,           8'd0,  0, 0, 0, 0, 0);
`ifdef REFUND_EN
    // coin return, refund beats sel
    step("r_idle",      RF,            8'd0,  0, 0, 0, 0, 0);
    step("r_d1",        D,             8'd10, 0, 0, 0, 0, 0);
    step("r_d2",        D,             8'd20, 0, 0, 0, 0, 0);
    step("r_rf_sel",    RF | SEL,      8'd20, 0, 1, 1, 0, 0);
    step("r_ca1",       CA,            8'd15, 0, 1, 1, 0, 0);
    step("r_ca2",       CA,            8'd10, 0, 1, 1, 0, 0);
    step("r_ca3",       CA,            8'd5,  0, 1, 1, 0, 0);
    step("r_ca4",       CA,            8'd0,  0, 0, 0, 0, 0);
`endif
    @(negedge clk);
    rstn = 1'b1; q_in = 1'b0; d_in = 1'b0; n_in = 1'b0;
    sel = 1'b0; vend_done = 1'b0; coin_ack = 1'b0;
`ifdef REFUND_EN
    refund = 1'b0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameter PRICE, default 35, item price in cents; SHALL be a nonzero multiple of 5 and no greater than MAX_CREDIT.
REQ-002 Parameter MAX_CREDIT, default 100, credit ceiling in cents; SHALL be a multiple of 5 and no greater than 255.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rstn  input  1  reset; synchronous, active-low.
REQ-005 q_in  input  1  quarter (25) inserted; one-cycle pulse.
REQ-006 d_in  input  1  dime (10) inserted; one-cycle pulse.
REQ-007 n_in  input  1  nickel (5) inserted; one-cycle pulse.
REQ-008 sel  input  1  purchase request; one-cycle pulse.
REQ-009 vend_done  input  1  dispense mechanism ack; one-cycle pulse.
REQ-010 coin_ack  input  1  change hopper ack, one nickel paid out; one-cycle pulse.
REQ-011 refund  input  1  coin-return request; one-cycle pulse; present only with REFUND_EN.
REQ-012 vend_req  output  1  dispense request; level signal.
REQ-013 coin_req  output  1  pay-one-nickel request; level signal.
REQ-014 credit  output  8  current credit in cents; registered.
REQ-015 busy  output  1  high in VEND and CHANGE.
REQ-016 coin_reject  output  1  registered one-cycle pulse; coin refused.
REQ-017 deny  output  1  registered one-cycle pulse; sel refused.

Function
REQ-018 FSM states: IDLE (credit==0), CREDIT (credit>0), VEND, CHANGE. busy SHALL equal (state==VEND || state==CHANGE).
REQ-019 Coins accepted only in IDLE/CREDIT. If several coin inputs pulse in one cycle, priority is q > d > n; the others are dropped silently.
REQ-020 Accepted coin: credit += value on the same edge. If the sum would exceed MAX_CREDIT, credit is unchanged and coin_reject pulses on the next cycle.
REQ-021 A coin arriving in VEND/CHANGE SHALL be refused: credit unchanged, coin_reject pulses.
REQ-022 sel in IDLE/CREDIT is compared against the registered credit before any same-cycle coin. If credit >= PRICE, go to VEND; the same-cycle coin is still added. Otherwise deny pulses and the state is held.
REQ-023 sel in VEND/CHANGE SHALL be ignored, with no deny pulse.
REQ-024 vend_req SHALL be high exactly while in VEND. It goes high the cycle after the accepted sel and holds until vend_done.
REQ-025 vend_done in VEND: credit -= PRICE. Next state is CHANGE if the remainder > 0, else IDLE. vend_done outside VEND SHALL be ignored.
REQ-026 coin_req SHALL be high exactly while in CHANGE.
REQ-027 Each coin_ack in CHANGE: credit -= 5. When credit reaches 0, go to IDLE and drop coin_req on that same edge. coin_ack outside CHANGE SHALL be ignored.
REQ-028 credit SHALL always be a multiple of 5, SHALL never exceed MAX_CREDIT and SHALL never underflow.
REQ-029 vend_done and coin_ack arriving in the same cycle: only the one matching the current state acts.

Reset
REQ-030 rstn low at a clock edge SHALL force IDLE, credit=0, and vend_req, coin_req, busy, coin_reject, deny all 0.
REQ-031 Reset mid-VEND or mid-CHANGE SHALL abandon the transaction. Remaining credit is discarded and the request drops on the reset edge.
REQ-032 Inputs sampled during reset SHALL have no effect.

Configuration
REQ-033 Macro REFUND_EN defined: refund port exists. refund in CREDIT enters CHANGE and pays out the full credit via REQ-027. refund in IDLE/VEND/CHANGE is ignored. refund together with sel in the same cycle: refund wins and deny does not pulse.
REQ-034 Macro REFUND_EN undefined: no refund port; credit leaves only via vend and change.

Verification
REQ-035 Sequence q, d, sel, vend_done, 0 coin_acks (PRICE=35). Required: credit 25 then 35; vend_req high from the cycle after sel; credit 0; IDLE with no coin_req.
REQ-036 Sequence q, q, sel, vend_done, then 3 coin_acks. Required: credit 50 then 15; coin_req held through 3 acks; credit 10, 5, 0; IDLE.
REQ-037 With credit=10, pulse sel. Required: deny one cycle, credit 10, state CREDIT, vend_req 0.
REQ-038 With credit=95, pulse q, then n, then q and d in the same cycle. Required: q → coin_reject with credit 95; n → credit 100; q+d → coin_reject with credit 100.
REQ-039 Pulse n while vend_req is high, then drop rstn during CHANGE. Required: coin_reject with credit unchanged; on the reset edge credit 0, coin_req 0, IDLE.
REQ-040 REFUND_EN defined, credit=20, refund and sel pulsed together. Required: CHANGE, no deny, 4 coin_acks bring credit to 0, then IDLE.
